// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, and holds the result for the decoder.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect raises fetch_misalign and halts).
module inst_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fetch_misalign
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pc_q_reg, pc_q_next;
    logic [31:0]     inst_q_reg, inst_q_next;
    logic            kill_reg, kill_next;
    logic            misalign_next;
    logic            redirect_bad;
    logic [XLEN-1:0] redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_reg;

    assign redirect_bad    = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= misalign_next;
        end
    end

    assign fetch_misalign = misalign_reg;
`else
    // Without the check, low target bits are simply dropped so the PC stays word aligned.
    assign redirect_bad    = 1'b0;
    assign redirect_target = {redirect_pc[XLEN-1:2], redirect_pc[1:0] & 2'b00};
    assign fetch_misalign  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            pc_q_reg   <= '0;
            inst_q_reg <= '0;
            kill_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            pc_q_reg   <= pc_q_next;
            inst_q_reg <= inst_q_next;
            kill_reg   <= kill_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pc_q_next     = pc_q_reg;
        inst_q_next   = inst_q_reg;
        kill_next     = kill_reg;
        misalign_next = fetch_misalign;

        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end

            REQ: begin
                if (redirect_bad) begin
                    misalign_next = 1'b1;
                    state_next    = HALTED;
                end else if (redirect_valid) begin
                    pc_next = redirect_target;
                    // An accepted request to the old PC must have its response discarded.
                    if (imem_req_ready) begin
                        kill_next  = 1'b1;
                        state_next = WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (redirect_bad) begin
                    misalign_next = 1'b1;
                    state_next    = HALTED;
                end else if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (imem_rsp_valid) begin
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        kill_next = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_reg) begin
                        kill_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        inst_q_next = imem_rsp_data;
                        pc_q_next   = pc_reg;
                        state_next  = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect_bad) begin
                    misalign_next = 1'b1;
                    state_next    = HALTED;
                end else if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = REQ;
                end else if (inst_ready) begin
                    if (halt) begin
                        state_next = HALTED;
                    end else begin
                        pc_next    = pc_reg + XLEN'(4);
                        state_next = REQ;
                    end
                end
            end

            HALTED: begin
                state_next = HALTED;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state_reg == REQ);
    assign imem_req_addr  = (state_reg == REQ) ? pc_reg : '0;
    // A redirect in HOLD withdraws the instruction in the same cycle so it cannot be consumed.
    assign inst_valid     = (state_reg == HOLD) & ~redirect_valid;
    assign inst           = inst_q_reg;
    assign inst_pc        = pc_q_reg;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the npc core: owns the PC, issues one request at a time to instruction memory, and holds the returned 32-bit instruction for the decoder with a valid/ready handshake. It sits directly upstream of the decoder. It accepts PC redirects from jal/jalr/branch resolution, and a halt indication when the decoder flags ebreak.

## Interface
Parameters:
- RESET_PC, 64'h8000_0000, first fetch address after reset
- XLEN, 64, PC/address width

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch address (current PC)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  response data valid (one cycle pulse)
- imem_rsp_data  in  32  fetched instruction
- inst_valid  out  1  instruction held for decoder
- inst  out  32  held instruction
- inst_pc  out  XLEN  PC of held instruction
- inst_ready  in  1  decoder/downstream consumes instruction
- redirect_valid  in  1  control-transfer redirect
- redirect_pc  in  XLEN  redirect target
- halt  in  1  consumed instruction is ebreak
- fetch_misalign  out  1  sticky misaligned-redirect flag

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALTED. Registers: pc, inst_q, pc_q, kill.
- IDLE: entered on reset; all outputs 0; next cycle -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_valid & imem_req_ready -> WAIT. imem_rsp_valid ignored in REQ.
- WAIT: on imem_rsp_valid: if kill, drop data, clear kill, -> REQ; else inst_q<=imem_rsp_data, pc_q<=pc, -> HOLD.
- HOLD: inst_valid=1, inst=inst_q, inst_pc=pc_q. On handshake (inst_valid & inst_ready): if halt -> HALTED; else pc<=pc+4 (mod 2^XLEN), -> REQ.
- HALTED: absorbing until reset; no requests; inst_valid=0; redirect ignored.
- Redirect (priority over all else except HALTED/IDLE): pc<=redirect_pc.
  - REQ: if req accepted same cycle -> WAIT with kill=1; else stay REQ with new address (imem tolerates address change while valid).
  - WAIT: kill<=1; if imem_rsp_valid same cycle, data dropped and -> REQ.
  - HOLD: inst_valid forced 0 combinationally (inst_valid = HOLD & ~redirect_valid); held instruction discarded, -> REQ.
- Only one outstanding request at any time.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=0, inst_valid=0, inst=0, inst_pc=0, fetch_misalign=0; pc=RESET_PC, kill=0, state=IDLE.
- First imem_req_valid one cycle after rst deasserts.
- imem_rsp_valid arrives >=1 cycle after request acceptance; same-cycle response is illegal.
- Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and inst_ready=1.
- inst/inst_pc stable while inst_valid=1 and not consumed.
- Reset asserted mid-operation: immediately -> IDLE; any later response to the pre-reset request arrives in IDLE/REQ and is ignored.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 (sticky until reset) and goes to HALTED; no request to the target is issued.
- Undefined: fetch_misalign tied 0; redirect_pc[1:0] forced to 2'b00 when loaded into pc.

## Test plan
- Reset release, zero-wait memory returning 32'h00000013, inst_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008, inst_valid every 3rd cycle, inst_pc matches.
- inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc unchanged, no new imem_req_valid; consumed on release, next address +4.
- redirect_valid with redirect_pc=0x80000100 during WAIT, response 2 cycles later -> response dropped, inst_valid stays 0, next request at 0x80000100.
- redirect in HOLD, same cycle inst_ready=1 -> inst_valid=0 that cycle, next request at redirect_pc, held instruction never consumed.
- halt=1 with handshake on 32'h00100073 -> HALTED, no further imem_req_valid for 20 cycles; rst pulse mid-WAIT -> restart at RESET_PC, stale response ignored.
- With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x80000102 -> fetch_misalign=1, HALTED; without it, next request at 0x80000100.
